// File: rtl/abs_diff_exhaustive_checker.sv
// Exhaustive stimulus driver and error checker for approximate |A-B| netlists.
// Optional first-failure capture is enabled by defining ABS_DIFF_CHK_FIRST_FAIL_EN.
module abs_diff_exhaustive_checker #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned ET      = 6,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [IN_W-1:0]       stim,
  input  logic [OUT_W-1:0]      approx,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [OUT_W-1:0]      max_err,
  output logic [IN_W+OUT_W-1:0] err_sum,
  output logic [IN_W:0]         viol_cnt,
  output logic                  ff_valid,
  output logic [IN_W-1:0]       ff_vec,
  output logic [OUT_W-1:0]      ff_val
);

  localparam int unsigned HALF_W = IN_W / 2;
  localparam int unsigned SUM_W  = IN_W + OUT_W;
  localparam int unsigned CNT_W  = IN_W + 1;
  localparam int unsigned DCNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [IN_W-1:0]     stim_nxt;
  logic [DCNT_W-1:0]   drain_cnt, drain_cnt_nxt;
  logic                clr;
  logic                issue;

  logic [HALF_W-1:0]   op_a, op_b, op_d;
  logic [OUT_W-1:0]    issue_exact;

  logic                smp_vld;
  logic                smp_take;
  logic [OUT_W-1:0]    smp_exact;
  logic [OUT_W:0]      err_w;
  logic [OUT_W-1:0]    err;
  logic                viol;

  logic [OUT_W-1:0]    max_nxt;
  logic [SUM_W-1:0]    sum_nxt;
  logic [CNT_W-1:0]    viol_nxt;

  // Exact reference for the vector currently on stim
  assign op_a = stim[HALF_W-1:0];
  assign op_b = stim[IN_W-1:HALF_W];

  always_comb begin
    op_d = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
    issue_exact = OUT_W'(op_d);
  end

  // Sweep sequencing; abort overrides everything, including start
  always_comb begin
    state_nxt     = state;
    stim_nxt      = stim;
    drain_cnt_nxt = drain_cnt;
    clr           = 1'b0;
    issue         = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr       = 1'b1;
          stim_nxt  = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (stim == {IN_W{1'b1}}) begin
          drain_cnt_nxt = '0;
          state_nxt     = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          stim_nxt = stim + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DCNT_W'(DUT_LAT - 1)) begin
          state_nxt = S_DONE;
        end else begin
          drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      stim_nxt  = '0;
      clr       = 1'b0;
      issue     = 1'b0;
    end
  end

  // Expected-value pipeline aligning each reference with the DUT's response
  if (DUT_LAT == 0) begin : g_nolat
    assign smp_vld   = issue;
    assign smp_exact = issue_exact;
`ifdef ABS_DIFF_CHK_FIRST_FAIL_EN
    logic [IN_W-1:0] smp_vec;
    assign smp_vec = stim;
`endif
  end else begin : g_lat
    logic             pv [DUT_LAT];
    logic [OUT_W-1:0] pe [DUT_LAT];
`ifdef ABS_DIFF_CHK_FIRST_FAIL_EN
    logic [IN_W-1:0]  pvec [DUT_LAT];
    logic [IN_W-1:0]  smp_vec;
    assign smp_vec = pvec[DUT_LAT-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DUT_LAT); i++) begin
          pv[i] <= 1'b0;
          pe[i] <= '0;
`ifdef ABS_DIFF_CHK_FIRST_FAIL_EN
          pvec[i] <= '0;
`endif
        end
      end else begin
        pv[0] <= issue;
        pe[0] <= issue_exact;
`ifdef ABS_DIFF_CHK_FIRST_FAIL_EN
        pvec[0] <= stim;
`endif
        for (int i = 1; i < int'(DUT_LAT); i++) begin
          pv[i] <= pv[i-1] & ~abort;
          pe[i] <= pe[i-1];
`ifdef ABS_DIFF_CHK_FIRST_FAIL_EN
          pvec[i] <= pvec[i-1];
`endif
        end
      end
    end

    assign smp_vld   = pv[DUT_LAT-1];
    assign smp_exact = pe[DUT_LAT-1];
  end

  assign smp_take = smp_vld & ~abort;

  // Absolute error, widened by one bit then saturated back to OUT_W
  always_comb begin
    if (approx >= smp_exact) begin
      err_w = {1'b0, approx} - {1'b0, smp_exact};
    end else begin
      err_w = {1'b0, smp_exact} - {1'b0, approx};
    end
    err  = err_w[OUT_W] ? {OUT_W{1'b1}} : err_w[OUT_W-1:0];
    viol = (32'(err) > ET);
  end

  // Accumulator next values
  always_comb begin
    max_nxt  = max_err;
    sum_nxt  = err_sum;
    viol_nxt = viol_cnt;
    if (clr) begin
      max_nxt  = '0;
      sum_nxt  = '0;
      viol_nxt = '0;
    end else if (smp_take) begin
      if (err > max_err) begin
        max_nxt = err;
      end
      sum_nxt = err_sum + SUM_W'(err);
      if (viol) begin
        viol_nxt = viol_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stim      <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      max_err   <= '0;
      err_sum   <= '0;
      viol_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      stim      <= stim_nxt;
      drain_cnt <= drain_cnt_nxt;
      busy      <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done      <= (state_nxt == S_DONE);
      pass      <= (state_nxt == S_DONE) && (viol_nxt == '0);
      max_err   <= max_nxt;
      err_sum   <= sum_nxt;
      viol_cnt  <= viol_nxt;
    end
  end

`ifdef ABS_DIFF_CHK_FIRST_FAIL_EN
  logic [IN_W-1:0] ff_src_vec;
  assign ff_src_vec = (DUT_LAT == 0) ? g_nolat_vec() : g_lat_vec();

  function automatic logic [IN_W-1:0] g_nolat_vec();
    return stim;
  endfunction

  function automatic logic [IN_W-1:0] g_lat_vec();
    return stim;
  endfunction
`endif

`ifdef ABS_DIFF_CHK_FIRST_FAIL_EN
  logic [IN_W-1:0] cap_vec;
  if (DUT_LAT == 0) begin : g_cap0
    assign cap_vec = g_nolat.smp_vec;
  end else begin : g_capn
    assign cap_vec = g_lat.smp_vec;
  end

  // First violating sample of a sweep is kept; later ones are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
      ff_val   <= '0;
    end else if (clr) begin
      ff_valid <= 1'b0;
      ff_vec   <= '0;
      ff_val   <= '0;
    end else if (smp_take && viol && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_vec   <= cap_vec;
      ff_val   <= approx;
    end
  end
`else
  assign ff_valid = 1'b0;
  assign ff_vec   = '0;
  assign ff_val   = '0;
`endif

endmodule

// File: tb/tb_abs_diff_exhaustive_checker.sv
// Scoreboard bench for abs_diff_exhaustive_checker: a zero-latency and a
// three-cycle-latency instance, each fed by a small behavioural DUT model.
module tb_abs_diff_exhaustive_checker;

  typedef struct {
    logic [3:0]  max_err;
    logic [11:0] err_sum;
    logic [8:0]  viol;
    logic        pass;
    int          cycles;
    logic        ffv;
    logic [7:0]  ffvec;
    logic [3:0]  ffval;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0;
  logic start3 = 1'b0, abort3 = 1'b0;
  int   mode = 0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0]  stim0, stim3;
  logic [3:0]  approx0, approx3;
  logic        busy0, done0, pass0, busy3, done3, pass3;
  logic [3:0]  max0, max3;
  logic [11:0] sum0, sum3;
  logic [8:0]  viol0, viol3;
  logic        ffv0, ffv3;
  logic [7:0]  ffvec0, ffvec3;
  logic [3:0]  ffval0, ffval3;
  logic [3:0]  r1, r2, r3;

  exp_t q0[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] model(input int m, input logic [7:0] s);
    logic [3:0] a, b, e;
    a = s[3:0];
    b = s[7:4];
    e = (a >= b) ? (a - b) : (b - a);
    case (m)
      1:       return 4'h0;
      2:       return e ^ 4'b0001;
      default: return e;
    endcase
  endfunction

  assign approx0 = model(mode, stim0);

  always @(posedge clk) begin
    r1 <= model(0, stim3);
    r2 <= r1;
    r3 <= r2;
  end
  assign approx3 = r3;

  abs_diff_exhaustive_checker #(.IN_W(8), .OUT_W(4), .ET(6), .DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .stim(stim0), .approx(approx0), .busy(busy0), .done(done0), .pass(pass0),
    .max_err(max0), .err_sum(sum0), .viol_cnt(viol0),
    .ff_valid(ffv0), .ff_vec(ffvec0), .ff_val(ffval0)
  );

  abs_diff_exhaustive_checker #(.IN_W(8), .OUT_W(4), .ET(6), .DUT_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .stim(stim3), .approx(approx3), .busy(busy3), .done(done3), .pass(pass3),
    .max_err(max3), .err_sum(sum3), .viol_cnt(viol3),
    .ff_valid(ffv3), .ff_vec(ffvec3), .ff_val(ffval3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Hand-computed sweep results over the 16x16 operand space
  function automatic exp_t mk_exp(input int m, input int cycles);
    exp_t e;
    e.cycles = cycles;
    e.ffv = 1'b0;
    e.ffvec = 8'h00;
    e.ffval = 4'h0;
    case (m)
      1: begin
        e.max_err = 4'd15; e.err_sum = 12'd1360; e.viol = 9'd90; e.pass = 1'b0;
`ifdef ABS_DIFF_CHK_FIRST_FAIL_EN
        e.ffv = 1'b1; e.ffvec = 8'h07; e.ffval = 4'h0;
`endif
      end
      2: begin
        e.max_err = 4'd1; e.err_sum = 12'd256; e.viol = 9'd0; e.pass = 1'b1;
      end
      default: begin
        e.max_err = 4'd0; e.err_sum = 12'd0; e.viol = 9'd0; e.pass = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic cmp_result(input string tag, input exp_t e, input logic [3:0] mx,
                            input logic [11:0] sm, input logic [8:0] vc, input logic ps,
                            input int cycles, input logic fv, input logic [7:0] fvec,
                            input logic [3:0] fval);
    chk({tag, "_max_err"}, 32'(mx), 32'(e.max_err));
    chk({tag, "_err_sum"}, 32'(sm), 32'(e.err_sum));
    chk({tag, "_viol_cnt"}, 32'(vc), 32'(e.viol));
    chk({tag, "_pass"}, 32'(ps), 32'(e.pass));
    chk({tag, "_sweep_cycles"}, 32'(cycles), 32'(e.cycles));
    chk({tag, "_ff_valid"}, 32'(fv), 32'(e.ffv));
    chk({tag, "_ff_vec"}, 32'(fvec), 32'(e.ffvec));
    chk({tag, "_ff_val"}, 32'(fval), 32'(e.ffval));
  endtask

  // Monitors: pop one expected record on every rising done
  int   t0 = 0, t3 = 0;
  logic pb0 = 1'b0, pd0 = 1'b0, pb3 = 1'b0, pd3 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pb0 = 1'b0; pd0 = 1'b0;
    end else begin
      if (busy0 && !pb0) t0 = cyc;
      if (done0 && !pd0) begin
        if (q0.size() == 0) begin
          chk("sb0_entry_at_done", 32'(q0.size()), 32'd1);
        end else begin
          cmp_result("lat0", q0.pop_front(), max0, sum0, viol0, pass0, cyc - t0,
                     ffv0, ffvec0, ffval0);
        end
      end
      pb0 = busy0;
      pd0 = done0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pb3 = 1'b0; pd3 = 1'b0;
    end else begin
      if (busy3 && !pb3) t3 = cyc;
      if (done3 && !pd3) begin
        if (q3.size() == 0) begin
          chk("sb3_entry_at_done", 32'(q3.size()), 32'd1);
        end else begin
          cmp_result("lat3", q3.pop_front(), max3, sum3, viol3, pass3, cyc - t3,
                     ffv3, ffvec3, ffval3);
        end
      end
      pb3 = busy3;
      pd3 = done3;
    end
  end

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start3 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string name);
    logic d;
    d = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      d = sel ? done3 : done0;
      if (d) break;
    end
    chk(name, 32'(d), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_stim", 32'(stim0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_max_err", 32'(max0), 32'd0);
    chk("rst_err_sum", 32'(sum0), 32'd0);
    chk("rst_viol_cnt", 32'(viol0), 32'd0);
    chk("rst_ff_valid", 32'(ffv0), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    rst_n = 1'b1;

    // Exact model
    mode = 0;
    q0.push_back(mk_exp(0, 256));
    pulse_start(1'b0);
    chk("run_busy", 32'(busy0), 32'd1);
    chk("run_first_stim", 32'(stim0), 32'd0);
    wait_done(1'b0, "done_exact");

    // approx stuck at zero, started from DONE
    mode = 1;
    q0.push_back(mk_exp(1, 256));
    pulse_start(1'b0);
    chk("restart_done_low", 32'(done0), 32'd0);
    wait_done(1'b0, "done_zero");

    // Single LSB flip on every vector
    mode = 2;
    q0.push_back(mk_exp(2, 256));
    pulse_start(1'b0);
    wait_done(1'b0, "done_xor");

    // abort while stim == 100: samples 0..99 already accumulated at err 1 each
    pulse_start(1'b0);
    repeat (100) @(negedge clk);
    chk("abort_stim_before", 32'(stim0), 32'd100);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_stim", 32'(stim0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_err_sum", 32'(sum0), 32'd100);
    chk("abort_max_err", 32'(max0), 32'd1);
    chk("abort_viol_cnt", 32'(viol0), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_err_sum_held", 32'(sum0), 32'd100);
    q0.push_back(mk_exp(2, 256));
    pulse_start(1'b0);
    chk("restart_cleared_sum", 32'(sum0), 32'd0);
    wait_done(1'b0, "done_after_abort");

    // abort beats start in the same cycle
    @(negedge clk);
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("abort_start_busy", 32'(busy0), 32'd0);
    chk("abort_start_done", 32'(done0), 32'd0);
    chk("abort_start_pass", 32'(pass0), 32'd0);

    // Three-cycle latency DUT
    q3.push_back(mk_exp(0, 259));
    pulse_start(1'b1);
    wait_done(1'b1, "done_lat3");

    // Asynchronous reset in the middle of a sweep
    mode = 1;
    pulse_start(1'b0);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stim", 32'(stim0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_err_sum", 32'(sum0), 32'd0);
    chk("arst_max_err", 32'(max0), 32'd0);
    chk("arst_viol_cnt", 32'(viol0), 32'd0);
    chk("arst_done3", 32'(done3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back(mk_exp(1, 256));
    pulse_start(1'b0);
    wait_done(1'b0, "done_after_reset");

    repeat (3) @(negedge clk);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb3_drained", 32'(q3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
